// File: rtl/prescaler_pkg.sv
// Shared types and mode encodings for the programmable sample-tick prescaler.
// Imported by the top and by anything decoding the config mode field.
package prescaler_pkg;

    typedef enum logic [1:0] {
        CONT   = 2'b00,
        BURST  = 2'b01,
        SINGLE = 2'b10,
        RSVD   = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] MODE_CONT   = 2'b00;
    localparam logic [1:0] MODE_BURST  = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Reserved encoding falls back to continuous, so only these two terminate.
    function automatic logic is_bounded(logic [1:0] m);
        return (m == MODE_BURST) || (m == MODE_SINGLE);
    endfunction

endpackage

// File: rtl/prog_prescaler_period_counter.sv
// Free-running period counter: counts 0..reload, strobes and wraps at reload.
// Clear has priority so a start always begins a fresh period.
module period_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_reload,
    output logic             o_tc
);

    logic [CNT_W-1:0] count;

    assign o_tc = i_en && (count == i_reload);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_en) begin
            count <= o_tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/prog_prescaler.sv
// Runtime-programmable sample-tick generator with continuous, burst and
// single-shot modes; config written during a run is shadowed until safe.
module prog_prescaler #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [CNT_W-1:0]   i_cfg_div,
    input  logic [1:0]         i_cfg_mode,
    input  logic [BURST_W-1:0] i_cfg_burst,
    input  logic               i_start,
    input  logic               i_stop,
    output logic               o_tick,
    output logic               o_busy,
    output logic               o_done,
    output logic [BURST_W-1:0] o_tick_count
);

    import prescaler_pkg::*;

    localparam logic [BURST_W-1:0] ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    state_e             state;
    logic [CNT_W-1:0]   act_div;
    logic [CNT_W-1:0]   sh_div;
    logic [1:0]         act_mode;
    logic [1:0]         sh_mode;
    logic [BURST_W-1:0] act_burst;
    logic [BURST_W-1:0] sh_burst;
    logic               pend;

    logic               tc;
    logic               start_go;
    logic               cnt_en;
    logic               last;
    logic [CNT_W-1:0]   eff_div;
    logic [1:0]         eff_mode;
    logic [BURST_W-1:0] eff_burst;
    logic [BURST_W-1:0] eff_len;
    logic [BURST_W-1:0] act_len;
    logic [BURST_W-1:0] next_cnt;

    assign o_cfg_ready = 1'b1;
    assign start_go    = (state == IDLE) && i_start && !i_stop;
    assign cnt_en      = (state == RUN) && !i_stop;

    // A config word arriving with start applies to that run.
    assign eff_div   = i_cfg_valid ? i_cfg_div   : sh_div;
    assign eff_mode  = i_cfg_valid ? i_cfg_mode  : sh_mode;
    assign eff_burst = i_cfg_valid ? i_cfg_burst : sh_burst;
    assign eff_len   = (eff_mode == MODE_SINGLE) ? ONE : eff_burst;
    assign act_len   = (act_mode == MODE_SINGLE) ? ONE : act_burst;
    assign next_cnt  = o_tick_count + ONE;
    assign last      = is_bounded(act_mode) && (next_cnt == act_len);

    period_counter #(
        .CNT_W(CNT_W)
    ) u_period (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (start_go),
        .i_en     (cnt_en),
        .i_reload (act_div),
        .o_tc     (tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            act_div      <= '0;
            sh_div       <= '0;
            act_mode     <= MODE_CONT;
            sh_mode      <= MODE_CONT;
            act_burst    <= '0;
            sh_burst     <= '0;
            pend         <= 1'b0;
            o_tick       <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_tick_count <= '0;
        end else begin
            o_tick <= 1'b0;
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_cfg_valid) begin
                        sh_div    <= i_cfg_div;
                        sh_mode   <= i_cfg_mode;
                        sh_burst  <= i_cfg_burst;
                        act_div   <= i_cfg_div;
                        act_mode  <= i_cfg_mode;
                        act_burst <= i_cfg_burst;
                    end
                    if (start_go) begin
                        act_div      <= eff_div;
                        act_mode     <= eff_mode;
                        act_burst    <= eff_burst;
                        pend         <= 1'b0;
                        o_tick_count <= '0;
                        if (is_bounded(eff_mode) && eff_len == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            state  <= RUN;
                            o_busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (i_stop) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (tc) begin
                        o_tick       <= 1'b1;
                        o_tick_count <= next_cnt;
                        if (pend) begin
                            act_div <= sh_div;
                            pend    <= 1'b0;
                        end
                        if (last) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end
                    end
                    // Placed last so a word landing on a reload stays pending.
                    if (i_cfg_valid) begin
                        sh_div   <= i_cfg_div;
                        sh_mode  <= i_cfg_mode;
                        sh_burst <= i_cfg_burst;
                        pend     <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_prescaler.sv
// Scoreboard bench for prog_prescaler: stimulus queues expected tick/done
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_prog_prescaler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_div = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_burst = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;

    logic        cfg_ready, tick, busy, done;
    logic [15:0] tick_count;
    logic        cfg_ready4, tick4, busy4, done4;
    logic [3:0]  tick_count4;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int cyc;
        int tick;
        int done;
        int busy;
        int cnt;
    } ev_t;

    ev_t q[$];

    prog_prescaler #(.CNT_W(16), .BURST_W(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_div    (cfg_div),
        .i_cfg_mode   (cfg_mode),
        .i_cfg_burst  (cfg_burst),
        .i_start      (start),
        .i_stop       (stop),
        .o_tick       (tick),
        .o_busy       (busy),
        .o_done       (done),
        .o_tick_count (tick_count)
    );

    prog_prescaler #(.CNT_W(16), .BURST_W(4)) dut_w4 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready4),
        .i_cfg_div    (cfg_div),
        .i_cfg_mode   (cfg_mode),
        .i_cfg_burst  (cfg_burst[3:0]),
        .i_start      (start),
        .i_stop       (stop),
        .o_tick       (tick4),
        .o_busy       (busy4),
        .o_done       (done4),
        .o_tick_count (tick_count4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(string name, int got, int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(int c);
        while (cyc < c) edge1();
    endtask

    task automatic at_neg(int c);
        wait_to(c);
        @(negedge clk);
    endtask

    task automatic drive(int v, int d, int m, int b, int s, int p,
                         output int e);
        cfg_valid = (v != 0);
        cfg_div   = 16'(d);
        cfg_mode  = 2'(m);
        cfg_burst = 16'(b);
        start     = (s != 0);
        stop      = (p != 0);
        edge1();
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        e = cyc;
    endtask

    task automatic expect_ev(int c, int t, int d, int b, int n);
        ev_t ev;
        ev.cyc  = c;
        ev.tick = t;
        ev.done = d;
        ev.busy = b;
        ev.cnt  = n;
        q.push_back(ev);
    endtask

    always @(negedge clk) begin : monitor
        ev_t ev;
        if (tick || done) begin
            n_total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_output: cyc %0d tick %0b done %0b cnt %0d",
                         cyc, tick, done, tick_count);
            end else begin
                ev = q.pop_front();
                if (ev.cyc == cyc && ev.tick == int'(tick) &&
                    ev.done == int'(done) && ev.busy == int'(busy) &&
                    ev.cnt == int'(tick_count)) begin
                    n_pass++;
                end else begin
                    $display("FAIL event: got cyc %0d tick %0b done %0b busy %0b cnt %0d, expected cyc %0d tick %0d done %0d busy %0d cnt %0d",
                             cyc, tick, done, busy, tick_count,
                             ev.cyc, ev.tick, ev.done, ev.busy, ev.cnt);
                end
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            n_total++;
            $display("FAIL missed_event: expected at cyc %0d cnt %0d, nothing by cyc %0d",
                     q[0].cyc, q[0].cnt, cyc);
            void'(q.pop_front());
        end
    end

    initial begin
        int e;
        int e0;
        int tmp;

        #2;
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(tick_count), 0);
        chk("cfg_ready", int'(cfg_ready), 1);
        edge1();
        edge1();
        rst_n = 1'b1;
        edge1();

        // continuous, div=3, stop after five ticks
        drive(1, 3, 0, 0, 0, 0, e);
        drive(0, 0, 0, 0, 1, 0, e);
        for (int k = 1; k <= 5; k++) expect_ev(e + 4 * k, 1, 0, 1, k);
        at_neg(e);
        chk("cont_busy_rise", int'(busy), 1);
        wait_to(e + 20);
        drive(0, 0, 0, 0, 0, 1, e);
        at_neg(e);
        chk("cont_busy_fall", int'(busy), 0);
        chk("cont_count", int'(tick_count), 5);
        wait_to(e + 8);

        // burst div=1 burst=3, config with start
        drive(1, 1, 1, 3, 1, 0, e);
        expect_ev(e + 2, 1, 0, 1, 1);
        expect_ev(e + 4, 1, 0, 1, 2);
        expect_ev(e + 6, 1, 1, 0, 3);
        at_neg(e + 7);
        chk("burst_idle", int'(busy), 0);
        chk("burst_count", int'(tick_count), 3);
        wait_to(e + 10);

        // single, div=0, burst field ignored
        drive(1, 0, 2, 5, 0, 0, e);
        drive(0, 0, 0, 0, 1, 0, e);
        expect_ev(e + 1, 1, 1, 0, 1);
        at_neg(e);
        chk("single_busy", int'(busy), 1);
        at_neg(e + 3);
        chk("single_count", int'(tick_count), 1);
        chk("single_idle", int'(busy), 0);

        // burst=0: done only
        drive(1, 2, 1, 0, 1, 0, e);
        expect_ev(e, 0, 1, 0, 0);
        at_neg(e + 4);
        chk("burst0_busy", int'(busy), 0);
        chk("burst0_count", int'(tick_count), 0);
        wait_to(e + 8);

        // divisor change mid-period, mode/burst deferred
        drive(1, 7, 0, 0, 1, 0, e);
        e0 = e;
        expect_ev(e0 + 8, 1, 0, 1, 1);
        expect_ev(e0 + 16, 1, 0, 1, 2);
        expect_ev(e0 + 19, 1, 0, 1, 3);
        expect_ev(e0 + 22, 1, 0, 1, 4);
        expect_ev(e0 + 25, 1, 0, 1, 5);
        wait_to(e0 + 9);
        drive(1, 2, 1, 2, 0, 0, tmp);
        wait_to(e0 + 25);
        drive(0, 0, 0, 0, 0, 1, e);
        at_neg(e);
        chk("shadow_busy", int'(busy), 0);
        chk("shadow_count", int'(tick_count), 5);
        edge1();
        drive(0, 0, 0, 0, 1, 0, e);
        expect_ev(e + 3, 1, 0, 1, 1);
        expect_ev(e + 6, 1, 1, 0, 2);
        at_neg(e + 8);
        chk("deferred_busy", int'(busy), 0);
        chk("deferred_count", int'(tick_count), 2);

        // start+stop together in IDLE
        drive(0, 0, 0, 0, 1, 1, e);
        at_neg(e);
        chk("startstop_busy", int'(busy), 0);
        chk("startstop_count", int'(tick_count), 2);
        wait_to(e + 8);

        // start in RUN ignored, stop on a tick-due cycle
        drive(1, 4, 0, 0, 1, 0, e0);
        expect_ev(e0 + 5, 1, 0, 1, 1);
        expect_ev(e0 + 10, 1, 0, 1, 2);
        wait_to(e0 + 2);
        drive(0, 0, 0, 0, 1, 0, tmp);
        wait_to(e0 + 14);
        drive(0, 0, 0, 0, 0, 1, e);
        at_neg(e);
        chk("stop_due_busy", int'(busy), 0);
        chk("stop_due_count", int'(tick_count), 2);
        wait_to(e + 8);

        // 17 ticks at div=0: 4-bit counter wraps to 1
        drive(1, 0, 0, 0, 1, 0, e0);
        for (int k = 1; k <= 17; k++) expect_ev(e0 + k, 1, 0, 1, k);
        wait_to(e0 + 17);
        drive(0, 0, 0, 0, 0, 1, e);
        at_neg(e);
        chk("wrap_count16", int'(tick_count), 17);
        chk("wrap_count4", int'(tick_count4), 1);
        chk("wrap_busy", int'(busy), 0);
        wait_to(e + 4);

        // asynchronous reset mid-burst
        drive(1, 3, 1, 4, 1, 0, e0);
        expect_ev(e0 + 4, 1, 0, 1, 1);
        wait_to(e0 + 8);
        chk("pre_rst_tick", int'(tick), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_tick", int'(tick), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_count", int'(tick_count), 0);
        chk("arst_count4", int'(tick_count4), 0);
        edge1();
        edge1();
        rst_n = 1'b1;
        edge1();
        drive(0, 0, 0, 0, 1, 0, e0);
        for (int k = 1; k <= 3; k++) expect_ev(e0 + k, 1, 0, 1, k);
        wait_to(e0 + 3);
        drive(0, 0, 0, 0, 0, 1, e);
        at_neg(e);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_count", int'(tick_count), 3);
        wait_to(e + 10);

        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_prescaler.md
# prog_prescaler

Runtime-programmable sample-tick generator for the logic analyzer's capture path. Successor to the fixed-divisor prescaler: the divisor is loaded at runtime through a valid/ready config port, and the block supports continuous, burst and single-shot modes with explicit start/stop, busy/done status and a tick counter. Its single-cycle `o_tick` strobe qualifies sampling in the capture/trigger logic. All logic runs in the system clock domain; no derived clocks.

## Interface
- `CNT_W`, 16: width of the divisor register and period counter.
- `BURST_W`, 16: width of the burst length and the tick counter.

- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_cfg_valid`  in  1  config word present.
- `o_cfg_ready`  out  1  config accept.
- `i_cfg_div`  in  CNT_W  divisor; tick period = div+1 cycles.
- `i_cfg_mode`  in  2  00 continuous, 01 burst, 10 single, 11 treated as continuous.
- `i_cfg_burst`  in  BURST_W  tick count for burst mode.
- `i_start`  in  1  start request, level sampled.
- `i_stop`  in  1  abort request, level sampled.
- `o_tick`  out  1  one-cycle sample strobe.
- `o_busy`  out  1  high while in RUN.
- `o_done`  out  1  one-cycle completion pulse.
- `o_tick_count`  out  BURST_W  ticks emitted in the current or last run.

## Operation
- States:
  - IDLE -> RUN on `i_start` with no `i_stop`.
  - RUN -> IDLE on `i_stop`, on the last burst tick, or on the single tick.
- `o_cfg_ready` is constant 1. A config word is accepted when `i_cfg_valid` is high.
  - In IDLE: written to the active registers and the shadow registers.
  - In RUN: written to the shadow only, and a pending flag is set.
    - The pending divisor becomes active on the cycle the counter reloads after a tick.
    - Pending mode and burst values become active only at the next start.
- Config and start in the same IDLE cycle: the new config applies to that run.
- Period counter, RUN only:
  - Increments each cycle.
  - When count == active div: pulse `o_tick`, reload count to 0, increment `o_tick_count` (wraps modulo 2^BURST_W).
- Burst mode:
  - After tick number `burst`, go to IDLE; `o_done` is high in the same cycle as that final tick.
  - Start with burst == 0: no RUN entry, no tick, `o_done` pulses once on the next cycle.
- Single mode: identical to burst with burst = 1, whatever `i_cfg_burst` holds.
- Continuous mode: runs until `i_stop`. Never asserts `o_done`.
- `i_stop` in RUN: IDLE on the next edge, no further tick, no `o_done`. A tick due in that same cycle is suppressed.
- `i_start` and `i_stop` together: stop wins.
- `i_start` while in RUN: ignored; the counter does not restart.
- At start: the counter clears to 0 and `o_tick_count` clears to 0. `o_tick_count` holds its value after the run ends.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE
  - `o_tick`, `o_busy`, `o_done` = 0
  - `o_tick_count` = 0
  - counter = 0
  - active and shadow div = 0, mode = continuous, burst = 0
  - pending flag clear
- Reset asserted mid-run aborts with no `o_done`.
- All outputs are registered.
- Start sampled at edge E:
  - `o_busy` = 1 from E+1.
  - First `o_tick` is high during the cycle after edge E+div+1.
  - Subsequent ticks every div+1 cycles.
- div = 0: `o_tick` is high every cycle while in RUN.
- `o_busy` falls on the edge after the final tick or after the stop is sampled.
- A divisor change in RUN never shortens or lengthens the period in progress. The first period using the new value starts at the reload after the next tick.

## Structure
- Package `prescaler_pkg` holds:
  - the mode enum (CONT, BURST, SINGLE, RSVD)
  - the state enum (IDLE, RUN)
  - localparams for the mode encodings
- Natural sub-module: `period_counter`, parametrised by CNT_W. Inputs: clear, enable, reload value. Output: terminal-count strobe.
- FSM, config shadowing and tick counting stay in the top module.

## Test plan
- Continuous, div=3, start: `o_tick` every 4 cycles, first 4 cycles after start. Stop after 5 ticks: `o_busy` 0 next edge, `o_tick_count`=5, no `o_done`.
- Burst, div=1, burst=3: ticks at 2-cycle spacing, `o_done` coincident with tick 3, then IDLE, `o_tick_count`=3.
- Single, div=0: exactly one tick on the cycle after `o_busy` rises, with `o_done` in the same cycle. Burst=0 in burst mode: `o_done` pulse, zero ticks, `o_busy` stays 0.
- Continuous, div=7 running: load div=2 mid-period. Current period stays 8 cycles, following periods are 3 cycles. Mode and burst written in RUN have no effect until the next start.
- Simultaneous events, each checked separately:
  - start+stop in IDLE: stays IDLE.
  - start in RUN: no restart.
  - stop on a tick-due cycle: tick suppressed.
  - Continuous run with BURST_W=4 for 17 ticks: `o_tick_count` wraps to 1.
- Assert `i_rst_n` low mid-burst: all outputs 0 immediately without waiting for a clock edge. After release, config registers are back at defaults and no `o_done` is seen.
